pe_mem_arbiter: RTL and testbench
=================================

PE_MEM_ARBITER -- requirements
Module: pe_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of both requester ports and the memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 req1 / req2  input  1  PE1/PE2 memory access request, from MemWrite or ResultSrc of that PE.
REQ-006 we1 / we2  input  1  PE1/PE2 access is a store (1) or load (0).
REQ-007 addr1 / addr2  input  ADDR_W  PE1/PE2 access address.
REQ-008 wdata1 / wdata2  input  DATA_W  PE1/PE2 store data.
REQ-009 stall1 / stall2  output  1  PE1/PE2 hold request and freeze pipeline.
REQ-010 done1 / done2  output  1  one-cycle completion pulse for PE1/PE2.
REQ-011 rdata1 / rdata2  output  DATA_W  PE1/PE2 load data, valid while done is high.
REQ-012 mem_req  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory store data.
REQ-016 mem_rdata  input  DATA_W  memory load data, valid with mem_ready.
REQ-017 mem_ready  input  1  memory completes the current access (variable latency, >=1 cycle).

Function
REQ-018 FSM states IDLE, ACCESS, DONE; registered owner bit (0=PE1, 1=PE2) and priority bit prio (0=PE1 first).
REQ-019 IDLE, no req -> stay IDLE; all mem_* outputs 0.
REQ-020 IDLE, one req -> grant it regardless of prio; both req -> grant PE selected by prio.
REQ-021 On grant: latch owner, we, addr, wdata of the granted PE into registers; next state ACCESS.
REQ-022 ACCESS: mem_req=1, mem_we/mem_addr/mem_wdata driven from latched registers, held stable until mem_ready sampled 1.
REQ-023 ACCESS with mem_ready=1: capture mem_rdata into rdata of owner if load; set prio to the non-owner PE; next state DONE.
REQ-024 DONE: done of owner =1 for exactly this cycle, mem_req=0, no arbitration; next state IDLE.
REQ-025 Minimum latency req->done = 2 cycles; minimum back-to-back period per access = 3 cycles.
REQ-026 stall1 = req1 & ~done1; stall2 = req2 & ~done2 (combinational).
REQ-027 rdata of a PE holds its last load value until its next load completes; stores leave rdata unchanged.
REQ-028 Requester dropping req during ACCESS is ignored; the latched access completes and done pulses.
REQ-029 Requester input changes during ACCESS do not affect mem_* outputs.
REQ-030 Both PEs continuously requesting -> grants strictly alternate; no PE waits more than one foreign access.
REQ-031 mem_ready while not in ACCESS is ignored.

Reset
REQ-032 rst low asynchronously forces state IDLE, prio=0, owner=0, all latched registers 0, rdata1/rdata2 0.
REQ-033 During and immediately after reset: mem_req, mem_we, done1, done2 = 0; stall outputs follow REQ-026.
REQ-034 Reset in ACCESS aborts the access: mem_req drops with rst without waiting for a clock; no done issued.

Verification
REQ-035 Reset, then req1=1, we1=0, addr1=0x100, mem_ready=1 first ACCESS cycle, mem_rdata=0xDEADBEEF -> mem_req one cycle, done1 two cycles after req, rdata1=0xDEADBEEF, prio=1.
REQ-036 req1 and req2 rise same cycle after reset, addr1=0x10, addr2=0x20 -> PE1 served first (mem_addr=0x10), then PE2 (mem_addr=0x20); stall2 high until done2.
REQ-037 Both continuously requesting stores for 12 cycles, mem_ready=1 -> grants alternate 1,2,1,2, each done pulse 3 cycles apart.
REQ-038 req2 store addr2=0x40 wdata2=0x55, mem_ready held 0 for 4 cycles, addr2 changed to 0x44 mid-access -> mem_addr stays 0x40, mem_wdata 0x55 for 5 cycles, then done2, rdata2 unchanged.
REQ-039 rst asserted low mid-ACCESS between clock edges -> mem_req 0 immediately, no done pulse, next grant after release uses prio=PE1.
REQ-040 mem_ready=1 pulsed in IDLE with no req -> no state change, no done, mem_req stays 0.

Source files
------------

// File: rtl/pe_mem_arbiter.sv
// Two-PE arbiter for one shared memory port: grants one access at a time,
// holds it stable until mem_ready, then pulses done and flips priority.
module pe_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic              req2,
  input  logic              we1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic              stall1,
  output logic              stall2,
  output logic              done1,
  output logic              done2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [DATA_W-1:0]   rdata2_q, rdata2_d;
  logic                grant2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    grant2   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          // A lone requester wins outright; prio only breaks a tie.
          grant2  = req2 && (!req1 || prio_q);
          owner_d = grant2;
          we_d    = grant2 ? we2    : we1;
          addr_d  = grant2 ? addr2  : addr1;
          wdata_d = grant2 ? wdata2 : wdata1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (!we_q) begin
            if (owner_q) rdata2_d = mem_rdata;
            else         rdata1_d = mem_rdata;
          end
          prio_d  = ~owner_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory outputs decode straight from the state register so an
  // asynchronous reset drops mem_req without waiting for a clock.
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  assign done1  = (state_q == DONE) && !owner_q;
  assign done2  = (state_q == DONE) &&  owner_q;
  assign stall1 = req1 && !done1;
  assign stall2 = req2 && !done2;
  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Scoreboard bench for pe_mem_arbiter: stimulus pushes expected memory
// accesses and completions, a monitor pops and compares them.
module tb_pe_mem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        pe;
    logic [31:0] rdata;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req2, we1, we2;
  logic [31:0] addr1, addr2, wdata1, wdata2;
  logic        stall1, stall2, done1, done2;
  logic [31:0] rdata1, rdata2;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int n_cmp = 0;
  int n_err = 0;
  int stamps[8];
  int mem_cycles;

  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];

  always #5 clk = ~clk;

  // Memory model: fixed word at 0x100, address-derived pattern elsewhere.
  assign mem_rdata = (mem_addr == 32'h100) ? 32'hDEADBEEF : (mem_addr ^ 32'hA5A5_0000);

  pe_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req1(req1), .req2(req2), .we1(we1), .we2(we2),
    .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
    .stall1(stall1), .stall2(stall2), .done1(done1), .done2(done2),
    .rdata1(rdata1), .rdata2(rdata2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  task automatic push_done(input logic pe, input logic [31:0] rdata);
    done_exp_t d;
    d.pe = pe; d.rdata = rdata;
    done_q.push_back(d);
  endtask

  // Count done pulses (negedge index from the drive edge), checking stall each cycle.
  task automatic wait_dones(input int n, input int budget, input bit drop_after);
    int  seen;
    int  cyc;
    bit  d1, d2;
    seen = 0; cyc = 0; mem_cycles = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      d1 = done1; d2 = done2;
      check("stall1", stall1, req1 && !d1);
      check("stall2", stall2, req2 && !d2);
      if (mem_req) mem_cycles++;
      if (d1 || d2) begin
        stamps[seen] = cyc;
        seen++;
      end
      cyc++;
      if (drop_after && (d1 || d2)) begin
        @(posedge clk); #1;
        if (d1) req1 = 1'b0;
        if (d2) req2 = 1'b0;
      end
    end
    if (seen < n) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", seen, n);
    end
  endtask

  // Monitor
  initial begin
    mem_exp_t  e;
    done_exp_t d;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mem_access: got addr 0x%08h expected none", mem_addr);
        end else begin
          e = mem_q.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          check("mem_wdata", mem_wdata, e.wdata);
          $display("txn mem   we=%0d addr=0x%08h wdata=0x%08h", mem_we, mem_addr, mem_wdata);
        end
      end
      if (done1 || done2) begin
        if (done1 && done2) begin
          n_cmp++; n_err++;
          $display("FAIL double_done: got done1=1 done2=1 expected one");
        end else if (done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done1=%0d done2=%0d expected none", done1, done2);
        end else begin
          d = done_q.pop_front();
          check("done_owner", {31'b0, done2}, {31'b0, d.pe});
          check("done_rdata", done2 ? rdata2 : rdata1, d.rdata);
          $display("txn done  PE%0d rdata=0x%08h", done2 ? 2 : 1, done2 ? rdata2 : rdata1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst = 1'b0; req1 = 1'b0; req2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    addr1 = '0; addr2 = '0; wdata1 = '0; wdata2 = '0; mem_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done1", done1, 0);
    check("rst_done2", done2, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_rdata2", rdata2, 0);
    req1 = 1'b1; #1;
    check("rst_stall1", stall1, 1);
    req1 = 1'b0; #1;
    check("rst_stall1_low", stall1, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_mem_req", mem_req, 0);

    // Single PE1 load, ready on first ACCESS cycle
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h100; wdata1 = '0;
    push_mem(1'b0, 32'h100, 32'h0);
    push_done(1'b0, 32'hDEADBEEF);
    wait_dones(1, 20, 1'b1);
    check("latency_req_done", stamps[0], 2);
    check("mem_req_cycles", mem_cycles, 1);

    // prio now favours PE2
    req1 = 1'b1; addr1 = 32'h10; req2 = 1'b1; we2 = 1'b0; addr2 = 32'h20; wdata2 = '0;
    push_mem(1'b0, 32'h20, 32'h0);
    push_mem(1'b0, 32'h10, 32'h0);
    push_done(1'b1, 32'hA5A50020);
    push_done(1'b0, 32'hA5A50010);
    wait_dones(2, 30, 1'b1);

    // Reset mid-ACCESS aborts the access
    mem_ready = 1'b0;
    req1 = 1'b1; addr1 = 32'h30;
    @(negedge clk);
    check("abort_c0_mem_req", mem_req, 0);
    @(negedge clk);
    check("abort_c1_mem_req", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_mem_req_async", mem_req, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_done1", done1, 0);
    check("abort_rdata1", rdata1, 0);
    check("abort_rdata2", rdata2, 0);
    req1 = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_no_done1", done1, 0);
    check("abort_no_done2", done2, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Simultaneous requests after reset: PE1 first
    req1 = 1'b1; addr1 = 32'h10; req2 = 1'b1; addr2 = 32'h20;
    push_mem(1'b0, 32'h10, 32'h0);
    push_mem(1'b0, 32'h20, 32'h0);
    push_done(1'b0, 32'hA5A50010);
    push_done(1'b1, 32'hA5A50020);
    wait_dones(2, 30, 1'b1);
    check("both_first_done", stamps[0], 2);
    check("both_second_done", stamps[1], 5);

    // Continuous stores from both: strict alternation, 3-cycle period
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h11111111;
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h84; wdata2 = 32'h22222222;
    for (int k = 0; k < 2; k++) begin
      push_mem(1'b1, 32'h80, 32'h11111111);
      push_done(1'b0, 32'hA5A50010);
      push_mem(1'b1, 32'h84, 32'h22222222);
      push_done(1'b1, 32'hA5A50020);
    end
    wait_dones(4, 40, 1'b0);
    @(posedge clk); #1;
    req1 = 1'b0; req2 = 1'b0;
    check("alt_first_done", stamps[0], 2);
    for (int k = 1; k < 4; k++) check("alt_period", stamps[k] - stamps[k-1], 3);

    // Stalled PE2 store with input changes mid-access
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h40; wdata2 = 32'h55; mem_ready = 1'b0;
    push_mem(1'b1, 32'h40, 32'h55);
    push_done(1'b1, 32'hA5A50020);
    @(negedge clk);
    check("hold_c0_mem_req", mem_req, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin addr2 = 32'h44; wdata2 = 32'h66; end
      if (i == 4) mem_ready = 1'b1;
      @(negedge clk);
      check("hold_mem_req", mem_req, 1);
      check("hold_mem_addr", mem_addr, 32'h40);
      check("hold_mem_wdata", mem_wdata, 32'h55);
      check("hold_mem_we", mem_we, 1);
      check("hold_no_done2", done2, 0);
    end
    @(negedge clk);
    check("hold_done2", done2, 1);
    check("hold_rdata2", rdata2, 32'hA5A50020);
    @(posedge clk); #1 req2 = 1'b0;

    // mem_ready toggling while idle is ignored
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 mem_ready = (i % 2 == 0);
      @(negedge clk);
      check("idle_mem_req", mem_req, 0);
      check("idle_done1", done1, 0);
      check("idle_done2", done2, 0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h100; wdata1 = '0;
    push_mem(1'b0, 32'h100, 32'h0);
    push_done(1'b0, 32'hDEADBEEF);
    wait_dones(1, 20, 1'b1);
    check("idle_then_latency", stamps[0], 2);

    repeat (3) @(negedge clk);
    check("mem_q_empty", mem_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
